// File: rtl/sim_axi_slave_regs.sv
// AXI4-Lite register bank responder: byte-strobed writes, SLVERR outside the bank,
// one outstanding write and one outstanding read, fully independent paths.
module sim_axi_slave_regs #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 16
) (
  input  logic                               s_axi_aclk,
  input  logic                               s_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                         s_axi_awprot,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                         s_axi_arprot,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int B      = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA = AXI_DATA_WIDTH'(32'hDEADBEEF);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + B)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [AXI_ADDR_WIDTH-1:0] a);
    return a[IDX_W+B-1:B];
  endfunction

  logic                      aw_held_q, aw_held_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      w_held_q, w_held_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      rvalid_q, rvalid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]       pulse_q, pulse_d;
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, w_in_range;
  logic [IDX_W-1:0] w_idx;

  // A transfer happens on an edge where valid and ready are both high; the
  // source holds valid and its payload until then, and ready never looks at valid.
  assign s_axi_awready = !aw_held_q && !bvalid_q;
  assign s_axi_wready  = !w_held_q && !bvalid_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_wr_pulse  = pulse_q;

  assign aw_hs      = s_axi_awvalid && s_axi_awready;
  assign w_hs       = s_axi_wvalid && s_axi_wready;
  assign ar_hs      = s_axi_arvalid && s_axi_arready;
  assign b_hs       = bvalid_q && s_axi_bready;
  assign r_hs       = rvalid_q && s_axi_rready;
  assign commit     = aw_held_q && w_held_q && !bvalid_q;
  assign w_in_range = in_range(addr_q);
  assign w_idx      = idx_of(addr_q);

  always_comb begin
    aw_held_d = aw_held_q;
    addr_d    = addr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      addr_d    = s_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
      if (w_in_range) begin
        pulse_d[w_idx] = 1'b1;
        for (int k = 0; k < STRB_W; k++) begin
          if (wstrb_q[k]) regs_d[w_idx][k*8 +: 8] = wdata_q[k*8 +: 8];
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
  end

  // Read samples regs_q, so a same-edge write commit is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (in_range(s_axi_araddr)) begin
        rdata_d = regs_q[idx_of(s_axi_araddr)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = ERR_DATA;
        rresp_d = RESP_SLVERR;
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held_q <= 1'b0;
      addr_q    <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      addr_q    <= addr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[i];
  end

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, addr_q[B-1:0], s_axi_araddr[B-1:0]};

endmodule

// File: tb/tb_sim_axi_slave_regs.sv
// Directed bench for sim_axi_slave_regs: drivers push expected B/R responses,
// a negedge monitor pops and compares on every B/R handshake.
module tb_sim_axi_slave_regs;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0] reg_wr_pulse;

  sim_axi_slave_regs #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  int aw_hs_cyc, w_hs_cyc, ar_hs_cyc;
  int b_rise_cyc = -1;
  int r_rise_cyc = -1;
  int pulse_cnt[NR];
  int pulse_total = 0;
  logic prev_b = 1'b0;
  logic prev_r = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_total++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  function automatic logic [DW-1:0] regv(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && !prev_b) b_rise_cyc = cyc;
      if (rvalid && !prev_r) r_rise_cyc = cyc;
      for (int i = 0; i < NR; i++) begin
        if (reg_wr_pulse[i]) begin
          pulse_cnt[i]++;
          pulse_total++;
        end
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          n_total++;
          $display("FAIL b_unexpected: bresp 0x%0h with nothing expected", bresp);
        end else begin
          check("bresp", {62'd0, bresp}, {62'd0, exp_b_q.pop_front()});
        end
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          n_total++;
          $display("FAIL r_unexpected: rresp/rdata 0x%0h with nothing expected", {rresp, rdata});
        end else begin
          check("rresp_rdata", {30'd0, rresp, rdata}, {30'd0, exp_r_q.pop_front()});
        end
      end
    end
    prev_b = bvalid;
    prev_r = rvalid;
  end

  // drivers
  task automatic drive_aw(input logic [AW-1:0] a);
    bit hs = 1'b0;
    awaddr = a;
    awvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      hs = awready;
      if (hs) aw_hs_cyc = cyc;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) fail_bound("aw_handshake");
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bit hs = 1'b0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      hs = wready;
      if (hs) w_hs_cyc = cyc;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) fail_bound("w_handshake");
    wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [AW-1:0] a);
    bit hs = 1'b0;
    araddr = a;
    arvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      hs = arready;
      if (hs) ar_hs_cyc = cyc;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) fail_bound("ar_handshake");
    arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_b_q.size() == 0 && exp_r_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) fail_bound("response_drain");
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input logic [1:0] exp);
    exp_b_q.push_back(exp);
    fork
      drive_aw(a);
      drive_w(d, s);
    join
    wait_drain();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] er, input logic [DW-1:0] ed);
    exp_r_q.push_back({er, ed});
    drive_ar(a);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NR*DW-1:0] snap;
    int snap_pulses, ok;
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state, first cycle out of reset
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    check("rst_reg_out_or", |reg_out, 0);
    @(posedge clk); #1;

    // full write to reg 2, then read it back
    do_write(32'h08, 32'h1234_5678, 4'hF, 2'b00);
    repeat (2) @(posedge clk); #1;
    check("wr_b_latency", b_rise_cyc - w_hs_cyc, 2);
    check("wr_pulse_reg2", pulse_cnt[2], 1);
    check("wr_pulse_total", pulse_total, 1);
    check("wr_reg_out2", regv(2), 32'h1234_5678);
    do_read(32'h08, 2'b00, 32'h1234_5678);
    check("rd_latency", r_rise_cyc - ar_hs_cyc, 1);

    // partial strobe: bytes 0 and 2 replaced
    do_write(32'h08, 32'hAABB_CCDD, 4'b0101, 2'b00);
    do_read(32'h08, 2'b00, 32'h12BB_56DD);
    check("strb_pulse_reg2", pulse_cnt[2], 2);

    // W five cycles ahead of AW, bready held low
    bready = 1'b0;
    exp_b_q.push_back(2'b00);
    drive_w(32'hCAFE_F00D, 4'hF);
    ok = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!wready && !bvalid) ok++;
      @(posedge clk); #1;
    end
    check("skew_wready_low", ok, 5);
    drive_aw(32'h14);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bvalid) begin
        ok = cyc;
        break;
      end
    end
    if (ok == 0) fail_bound("skew_bvalid");
    else check("skew_b_latency", ok - aw_hs_cyc, 2);
    ok = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid && bresp == 2'b00 && !awready) ok++;
    end
    check("skew_b_stall_stable", ok, 4);
    @(posedge clk); #1;
    bready = 1'b1;
    wait_drain();
    check("skew_reg_out5", regv(5), 32'hCAFE_F00D);

    // out of range at 0x40
    snap = reg_out;
    snap_pulses = pulse_total;
    do_write(32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10);
    repeat (2) @(posedge clk); #1;
    check("oor_regs_unchanged", reg_out == snap, 1);
    check("oor_no_pulse", pulse_total, snap_pulses);
    do_read(32'h40, 2'b10, 32'hDEAD_BEEF);

    // same-edge write commit and read of reg 3
    do_write(32'h0C, 32'h1, 4'hF, 2'b00);
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({2'b00, 32'h1});
    fork
      drive_aw(32'h0C);
      drive_w(32'h2, 4'hF);
      begin
        @(posedge clk); #1;
        drive_ar(32'h0C);
      end
    join
    wait_drain();
    check("same_edge_alignment", ar_hs_cyc - aw_hs_cyc, 1);
    do_read(32'h0C, 2'b00, 32'h2);

    // reset with both responses pending
    bready = 1'b0;
    rready = 1'b0;
    fork
      drive_aw(32'h04);
      drive_w(32'h5A5A_5A5A, 4'hF);
    join
    drive_ar(32'h04);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bvalid && rvalid) break;
    end
    check("pre_rst_bvalid", bvalid, 1);
    check("pre_rst_rvalid", rvalid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_reg_out_or", |reg_out, 0);
    check("mid_rst_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_b", bvalid, 0);
    check("post_rst_no_r", rvalid, 0);
    check("exp_b_left", exp_b_q.size(), 0);
    check("exp_r_left", exp_r_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
